// File: rtl/ccu.sv
// Central control unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
// with memory-ack timeouts, sticky trap state and retired-instruction count.
module ccu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ccu_i_imem_ack,
    input  logic        ccu_i_dmem_ack,
    input  logic        ccu_i_is_load,
    input  logic        ccu_i_is_store,
    input  logic        ccu_i_is_jump,
    input  logic        ccu_i_rd_we,
    input  logic        ccu_i_illegal,
    input  logic        ccu_i_branch_taken,
    output logic        ccu_o_imem_req,
    output logic        ccu_o_ir_we,
    output logic        ccu_o_exu_en,
    output logic        ccu_o_dmem_req,
    output logic        ccu_o_dmem_we,
    output logic        ccu_o_rf_we,
    output logic        ccu_o_pc_we,
    output logic        ccu_o_pc_sel,
    output logic [2:0]  ccu_o_state,
    output logic        ccu_o_trap,
    output logic [1:0]  ccu_o_trap_cause,
    output logic [31:0] ccu_o_instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  cause_q, cause_d;
    logic        run_q;
    logic        redir_q;
    logic        store_q;
    logic [31:0] instret_q;
    logic        exec_cyc;
    logic        wb_cyc;

    // State, wait counter, cause and run flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            cause_q <= 2'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            run_q   <= 1'b1;
        end
    end

    // Capture redirect and store class in EXEC, count retirements in WB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redir_q   <= 1'b0;
            store_q   <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            if (exec_cyc) begin
                redir_q <= ccu_i_branch_taken | ccu_i_is_jump;
                store_q <= ccu_i_is_store;
            end
            if (wb_cyc) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Next-state, wait counter and strobe decode
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        cause_d        = cause_q;
        exec_cyc       = 1'b0;
        wb_cyc         = 1'b0;
        ccu_o_imem_req = 1'b0;
        ccu_o_ir_we    = 1'b0;
        ccu_o_exu_en   = 1'b0;
        ccu_o_dmem_req = 1'b0;
        ccu_o_dmem_we  = 1'b0;
        ccu_o_rf_we    = 1'b0;
        ccu_o_pc_we    = 1'b0;
        ccu_o_pc_sel   = 1'b0;
        ccu_o_trap     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    ccu_o_imem_req = 1'b1;
                    if (ccu_i_imem_ack) begin
                        ccu_o_ir_we = 1'b1;
                        state_d     = S_DECODE;
                        wait_d      = 8'd0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = S_TRAP;
                        cause_d = 2'd2;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            S_DECODE: begin
                if (ccu_i_illegal) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_cyc     = 1'b1;
                ccu_o_exu_en = 1'b1;
                wait_d       = 8'd0;
                if (ccu_i_is_load | ccu_i_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                ccu_o_dmem_req = 1'b1;
                ccu_o_dmem_we  = store_q;
                if (ccu_i_dmem_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                wb_cyc       = 1'b1;
                ccu_o_pc_we  = 1'b1;
                ccu_o_rf_we  = ccu_i_rd_we;
                ccu_o_pc_sel = redir_q;
                wait_d       = 8'd0;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                ccu_o_trap = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
                cause_d = 2'd0;
            end
        endcase
    end

    assign ccu_o_state      = state_q;
    assign ccu_o_trap_cause = cause_q;
    assign ccu_o_instret    = instret_q;

endmodule

// File: tb/tb_ccu.sv
// Self-checking bench for ccu: random instruction mixes against a
// per-instruction cycle model, plus timeout, trap, reset and wrap cases.
module tb_ccu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic        is_jump = 1'b0;
    logic        rd_we = 1'b0;
    logic        illegal = 1'b0;
    logic        br_taken = 1'b0;
    logic        imem_req, ir_we, exu_en, dmem_req, dmem_we;
    logic        rf_we, pc_we, pc_sel, trap;
    logic [2:0]  state;
    logic [1:0]  cause;
    logic [31:0] instret;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret = 32'd0;

    ccu #(.TIMEOUT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .ccu_i_imem_ack     (imem_ack),
        .ccu_i_dmem_ack     (dmem_ack),
        .ccu_i_is_load      (is_load),
        .ccu_i_is_store     (is_store),
        .ccu_i_is_jump      (is_jump),
        .ccu_i_rd_we        (rd_we),
        .ccu_i_illegal      (illegal),
        .ccu_i_branch_taken (br_taken),
        .ccu_o_imem_req     (imem_req),
        .ccu_o_ir_we        (ir_we),
        .ccu_o_exu_en       (exu_en),
        .ccu_o_dmem_req     (dmem_req),
        .ccu_o_dmem_we      (dmem_we),
        .ccu_o_rf_we        (rf_we),
        .ccu_o_pc_we        (pc_we),
        .ccu_o_pc_sel       (pc_sel),
        .ccu_o_state        (state),
        .ccu_o_trap         (trap),
        .ccu_o_trap_cause   (cause),
        .ccu_o_instret      (instret)
    );

    always #5 clk = ~clk;

    // Packed view: state, 8 strobes, trap, cause
    function automatic logic [13:0] obs();
        return {state, imem_req, ir_we, exu_en, dmem_req, dmem_we,
                rf_we, pc_we, pc_sel, trap, cause};
    endfunction

    function automatic logic [13:0] mk(input int st, input bit im,
        input bit ir, input bit ex, input bit dr, input bit dw,
        input bit rf, input bit pw, input bit ps, input bit tr,
        input int c);
        return {3'(st), im, ir, ex, dr, dw, rf, pw, ps, tr, 2'(c)};
    endfunction

    task automatic idle_inputs();
        imem_ack = 0; dmem_ack = 0; is_load = 0; is_store = 0;
        is_jump = 0; rd_we = 0; illegal = 0; br_taken = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 0;
        #1;
        checks++;
        if (obs() !== mk(0,0,0,0,0,0,0,0,0,0,0) || instret !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got=%h/%h want=%h/0", obs(), instret,
                     mk(0,0,0,0,0,0,0,0,0,0,0));
        end
        exp_instret = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL imem_req_before_edge got=%b want=0", imem_req);
        end
    endtask

    // kind: 0 alu, 1 branch, 2 jump, 3 load, 4 store
    task automatic run_instr(input int kind, input int iw, input int dw,
                             input bit br);
        int  seq[$];
        int  fcnt = 0;
        int  mcnt = 0;
        bit  mem = (kind == 3) || (kind == 4);
        bit  st = (kind == 4);
        bit  wr = (kind == 0) || (kind == 2) || (kind == 3);
        bit  redir = ((kind == 1) && br) || (kind == 2);
        logic [13:0] e;
        for (int i = 0; i <= iw; i++) seq.push_back(0);
        seq.push_back(1);
        seq.push_back(2);
        if (mem) for (int i = 0; i <= dw; i++) seq.push_back(3);
        seq.push_back(4);
        foreach (seq[k]) begin
            @(negedge clk);
            is_load  = (kind == 3);
            is_store = st;
            is_jump  = (kind == 2);
            rd_we    = wr;
            illegal  = 0;
            br_taken = (kind == 1) ? br : 1'b0;
            if (seq[k] == 0) imem_ack = (fcnt == iw);
            else             imem_ack = 1'($urandom % 2);
            if (seq[k] == 3) dmem_ack = (mcnt == dw);
            else             dmem_ack = 1'($urandom % 2);
            #1;
            case (seq[k])
                0: e = mk(0,1,(fcnt == iw),0,0,0,0,0,0,0,0);
                1: e = mk(1,0,0,0,0,0,0,0,0,0,0);
                2: e = mk(2,0,0,1,0,0,0,0,0,0,0);
                3: e = mk(3,0,0,0,1,st,0,0,0,0,0);
                default: e = mk(4,0,0,0,0,0,wr,1,redir,0,0);
            endcase
            checks++;
            if (obs() !== e || instret !== exp_instret) begin
                failures++;
                $display("FAIL instr_k%0d_c%0d got=%h/%h want=%h/%h",
                         kind, k, obs(), instret, e, exp_instret);
            end
            if (seq[k] == 0) fcnt++;
            if (seq[k] == 3) mcnt++;
            if (seq[k] == 4) exp_instret = exp_instret + 32'd1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (instret !== exp_instret) begin
            failures++;
            $display("FAIL instret_after got=%h want=%h", instret, exp_instret);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if (obs() !== mk(0,1,0,0,0,0,0,0,0,0,0)) begin
            failures++;
            $display("FAIL imem_req_after_edge got=%h want=%h", obs(),
                     mk(0,1,0,0,0,0,0,0,0,0,0));
        end
        do_reset();
    endtask

    task automatic test_add();
        run_instr(0, 0, 0, 0);
    endtask

    task automatic test_branch();
        run_instr(1, 0, 0, 1);
        run_instr(1, 0, 0, 0);
        run_instr(2, 1, 0, 0);
    endtask

    task automatic test_store_delay();
        run_instr(4, 0, 3, 0);
        run_instr(3, 0, 3, 0);
    endtask

    task automatic test_fetch_boundary();
        run_instr(0, 3, 0, 0);
        run_instr(3, 3, 3, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom % 2));
        end
    endtask

    task automatic test_imem_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ack = 0;
            dmem_ack = 1'($urandom % 2);
            #1;
            checks++;
            if (obs() !== mk(0,1,0,0,0,0,0,0,0,0,0)) begin
                failures++;
                $display("FAIL imem_wait_%0d got=%h want=%h", i, obs(),
                         mk(0,1,0,0,0,0,0,0,0,0,0));
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            imem_ack = 1'($urandom % 2);
            dmem_ack = 1'($urandom % 2);
            #1;
            checks++;
            if (obs() !== mk(5,0,0,0,0,0,0,0,0,1,2)) begin
                failures++;
                $display("FAIL imem_trap_%0d got=%h want=%h", i, obs(),
                         mk(5,0,0,0,0,0,0,0,0,1,2));
            end
        end
        do_reset();
    endtask

    task automatic test_dmem_timeout();
        do_reset();
        is_load = 1; rd_we = 1;
        @(negedge clk); imem_ack = 1;
        @(negedge clk); imem_ack = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_ack = 0;
            imem_ack = 1'($urandom % 2);
            #1;
            checks++;
            if (obs() !== mk(3,0,0,0,1,0,0,0,0,0,0)) begin
                failures++;
                $display("FAIL dmem_wait_%0d got=%h want=%h", i, obs(),
                         mk(3,0,0,0,1,0,0,0,0,0,0));
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_ack = 1'($urandom % 2);
            #1;
            checks++;
            if (obs() !== mk(5,0,0,0,0,0,0,0,0,1,3)) begin
                failures++;
                $display("FAIL dmem_trap_%0d got=%h want=%h", i, obs(),
                         mk(5,0,0,0,0,0,0,0,0,1,3));
            end
        end
        do_reset();
    endtask

    task automatic test_illegal();
        run_instr(0, 0, 0, 0);
        @(negedge clk); imem_ack = 1;
        @(negedge clk); imem_ack = 0; illegal = 1;
        #1;
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL illegal_decode got=%0d want=1", state);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            illegal  = 1'($urandom % 2);
            imem_ack = 1'($urandom % 2);
            dmem_ack = 1'($urandom % 2);
            is_store = 1'($urandom % 2);
            #1;
            checks++;
            if (obs() !== mk(5,0,0,0,0,0,0,0,0,1,1) ||
                instret !== exp_instret) begin
                failures++;
                $display("FAIL illegal_trap_%0d got=%h/%h want=%h/%h", i,
                         obs(), instret, mk(5,0,0,0,0,0,0,0,0,1,1),
                         exp_instret);
            end
        end
        do_reset();
    endtask

    task automatic test_mem_reset();
        is_load = 1; rd_we = 1;
        @(negedge clk); imem_ack = 1;
        @(negedge clk); imem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (dmem_req !== 1'b1 || state !== 3'd3) begin
            failures++;
            $display("FAIL mem_entry got=%b/%0d want=1/3", dmem_req, state);
        end
        #1;
        rst = 0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || state !== 3'd0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL async_drop got=%b/%0d/%b want=0/0/0",
                     dmem_req, state, imem_req);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        #2;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        run_instr(0, 0, 0, 0);
        checks++;
        if (instret !== 32'd0) begin
            failures++;
            $display("FAIL instret_wrap got=%h want=0", instret);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_store_delay();
        test_fetch_boundary();
        test_random();
        test_imem_timeout();
        test_dmem_timeout();
        test_illegal();
        test_mem_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
